// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO register controller: register offsets,
// interrupt bit indices and the access FSM state type.
package gpio_ctrl_pkg;

    localparam logic [8:0] GPIO_DATA_OFS  = 9'h000;
    localparam logic [8:0] GPIO_TRI_OFS   = 9'h004;
    localparam logic [8:0] GPIO2_DATA_OFS = 9'h008;
    localparam logic [8:0] GPIO2_TRI_OFS  = 9'h00C;
    localparam logic [8:0] GIER_OFS       = 9'h11C;
    localparam logic [8:0] ISR_OFS        = 9'h120;
    localparam logic [8:0] IER_OFS        = 9'h128;

    localparam int GIER_EN_BIT = 31;
    localparam int CH1         = 0;
    localparam int CH2         = 1;

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    // Word match: byte-lane bits [1:0] never take part in decode.
    function automatic logic addr_hit(input logic [8:0] addr, input logic [8:0] ofs);
        return addr[8:2] == ofs[8:2];
    endfunction

endpackage

// File: rtl/gpio_chan.sv
// One GPIO channel: data/tri registers, two-flop input synchroniser and
// change detector over the bits currently configured as inputs.
module gpio_chan
    import gpio_ctrl_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] DOUT_DEF = 32'h0,
    parameter logic [31:0] TRI_DEF  = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_we,
    input  logic             tri_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             arm,
    input  logic [WIDTH-1:0] pins_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] tri_o,
    output logic [WIDTH-1:0] rd_o,
    output logic             chg_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] tri_q, tri_d;
    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;

    always_comb begin
        data_d = data_q;
        tri_d  = tri_q;
        if (data_we) data_d = wdata;
        if (tri_we)  tri_d  = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= DOUT_DEF[WIDTH-1:0];
            tri_q   <= TRI_DEF[WIDTH-1:0];
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            data_q  <= data_d;
            tri_q   <= tri_d;
            sync1_q <= pins_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign data_o = data_q;
    assign tri_o  = tri_q;
    assign rd_o   = (tri_q & sync2_q) | (~tri_q & data_q);
    // Output-mode bits are masked with the tri value of this cycle.
    assign chg_o  = arm & (|((sync2_q ^ prev_q) & tri_q));

endmodule

// File: rtl/gpio_ctrl.sv
// Register-mapped GPIO controller: req/ack register port, two channels,
// interrupt status/enable/global enable and a registered level interrupt.
//
//   state | meaning
//   IDLE  | waiting for reg_req; a request is executed on this edge
//   RESP  | reg_ack high for one cycle with reg_err/reg_rdata; reg_req ignored
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int          C_GPIO_WIDTH     = 32,
    parameter int          C_GPIO2_WIDTH    = 32,
    parameter int          C_IS_DUAL        = 1,
    parameter logic [31:0] C_DOUT_DEFAULT   = 32'h0,
    parameter logic [31:0] C_TRI_DEFAULT    = 32'hFFFF_FFFF,
    parameter logic [31:0] C_DOUT_DEFAULT_2 = 32'h0,
    parameter logic [31:0] C_TRI_DEFAULT_2  = 32'hFFFF_FFFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     reg_req,
    input  logic                     reg_we,
    input  logic [8:0]               reg_addr,
    input  logic [31:0]              reg_wdata,
    output logic                     reg_ack,
    output logic                     reg_err,
    output logic [31:0]              reg_rdata,
    input  logic [C_GPIO_WIDTH-1:0]  gpio_io_i,
    output logic [C_GPIO_WIDTH-1:0]  gpio_io_o,
    output logic [C_GPIO_WIDTH-1:0]  gpio_io_t,
    input  logic [C_GPIO2_WIDTH-1:0] gpio2_io_i,
    output logic [C_GPIO2_WIDTH-1:0] gpio2_io_o,
    output logic [C_GPIO2_WIDTH-1:0] gpio2_io_t,
    output logic                     ip2intc_irpt
);

    localparam bit DUAL = (C_IS_DUAL != 0);

    state_e      state_q;
    logic        ack_q, err_q;
    logic [31:0] rdata_q;

    logic [1:0]  isr_q, isr_d;
    logic [1:0]  ier_q, ier_d;
    logic        gier_q, gier_d;
    logic [1:0]  arm_q, arm_d;
    logic        irq_q, irq_d;

    logic hit_data, hit_tri, hit_data2, hit_tri2, hit_gier, hit_isr, hit_ier;
    logic mapped, accept, wr;
    logic armed;

    logic [C_GPIO_WIDTH-1:0]  ch1_rd;
    logic                     ch1_chg;
    logic [C_GPIO2_WIDTH-1:0] ch2_rd;
    logic                     ch2_chg;
    logic [31:0]              ext_rd1, ext_tri1, ext_rd2, ext_tri2, rdata_v;

    assign hit_data  = addr_hit(reg_addr, GPIO_DATA_OFS);
    assign hit_tri   = addr_hit(reg_addr, GPIO_TRI_OFS);
    assign hit_data2 = DUAL && addr_hit(reg_addr, GPIO2_DATA_OFS);
    assign hit_tri2  = DUAL && addr_hit(reg_addr, GPIO2_TRI_OFS);
    assign hit_gier  = addr_hit(reg_addr, GIER_OFS);
    assign hit_isr   = addr_hit(reg_addr, ISR_OFS);
    assign hit_ier   = addr_hit(reg_addr, IER_OFS);
    assign mapped    = hit_data | hit_tri | hit_data2 | hit_tri2 | hit_gier | hit_isr | hit_ier;

    assign accept = (state_q == IDLE) && reg_req;
    assign wr     = accept && reg_we;
    assign armed  = (arm_q == 2'd3);

    gpio_chan #(
        .WIDTH    (C_GPIO_WIDTH),
        .DOUT_DEF (C_DOUT_DEFAULT),
        .TRI_DEF  (C_TRI_DEFAULT)
    ) u_ch1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_we (wr && hit_data),
        .tri_we  (wr && hit_tri),
        .wdata   (reg_wdata[C_GPIO_WIDTH-1:0]),
        .arm     (armed),
        .pins_i  (gpio_io_i),
        .data_o  (gpio_io_o),
        .tri_o   (gpio_io_t),
        .rd_o    (ch1_rd),
        .chg_o   (ch1_chg)
    );

    generate
        if (C_IS_DUAL != 0) begin : g_ch2
            gpio_chan #(
                .WIDTH    (C_GPIO2_WIDTH),
                .DOUT_DEF (C_DOUT_DEFAULT_2),
                .TRI_DEF  (C_TRI_DEFAULT_2)
            ) u_ch2 (
                .clk     (clk),
                .rst_n   (rst_n),
                .data_we (wr && hit_data2),
                .tri_we  (wr && hit_tri2),
                .wdata   (reg_wdata[C_GPIO2_WIDTH-1:0]),
                .arm     (armed),
                .pins_i  (gpio2_io_i),
                .data_o  (gpio2_io_o),
                .tri_o   (gpio2_io_t),
                .rd_o    (ch2_rd),
                .chg_o   (ch2_chg)
            );
        end else begin : g_no_ch2
            logic unused_pins;
            assign unused_pins = ^gpio2_io_i;
            assign gpio2_io_o  = '0;
            assign gpio2_io_t  = '1;
            assign ch2_rd      = '0;
            assign ch2_chg     = 1'b0;
        end
    endgenerate

    logic unused_addr;
    assign unused_addr = ^reg_addr[1:0];

    always_comb begin
        ext_rd1  = '0;
        ext_tri1 = '0;
        ext_rd2  = '0;
        ext_tri2 = '0;
        ext_rd1[C_GPIO_WIDTH-1:0]   = ch1_rd;
        ext_tri1[C_GPIO_WIDTH-1:0]  = gpio_io_t;
        ext_rd2[C_GPIO2_WIDTH-1:0]  = ch2_rd;
        ext_tri2[C_GPIO2_WIDTH-1:0] = gpio2_io_t;
    end

    always_comb begin
        rdata_v = '0;
        if (hit_data)  rdata_v = ext_rd1;
        if (hit_tri)   rdata_v = ext_tri1;
        if (hit_data2) rdata_v = ext_rd2;
        if (hit_tri2)  rdata_v = ext_tri2;
        if (hit_gier)  rdata_v[GIER_EN_BIT] = gier_q;
        if (hit_isr)   rdata_v[1:0] = isr_q;
        if (hit_ier)   rdata_v[1:0] = ier_q;
    end

    always_comb begin
        isr_d  = isr_q;
        ier_d  = ier_q;
        gier_d = gier_q;
        arm_d  = armed ? arm_q : arm_q + 2'd1;
        if (wr && hit_isr)  isr_d  = isr_q ^ reg_wdata[1:0];
        if (wr && hit_ier)  ier_d  = reg_wdata[1:0];
        if (wr && hit_gier) gier_d = reg_wdata[GIER_EN_BIT];
        // Hardware set is applied after the toggle so it wins a collision.
        if (ch1_chg) isr_d[CH1] = 1'b1;
        if (ch2_chg) isr_d[CH2] = 1'b1;
        irq_d = gier_q & (|(isr_q & ier_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isr_q  <= '0;
            ier_q  <= '0;
            gier_q <= 1'b0;
            arm_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            isr_q  <= isr_d;
            ier_q  <= ier_d;
            gier_q <= gier_d;
            arm_q  <= arm_d;
            irq_q  <= irq_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (reg_req) begin
                        state_q <= RESP;
                        ack_q   <= 1'b1;
                        err_q   <= ~mapped;
                        rdata_q <= reg_we ? 32'h0 : rdata_v;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    assign reg_ack      = ack_q;
    assign reg_err      = err_q;
    assign reg_rdata    = rdata_q;
    assign ip2intc_irpt = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: a dual-channel instance for the main
// register/interrupt behaviour and a single-channel instance for the C_IS_DUAL=0 build.
module tb_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req0, we0;
    logic [8:0]  addr0;
    logic [31:0] wdata0;
    logic        ack0, err0, irq0;
    logic [31:0] rdata0;
    logic [31:0] gi0, go0, gt0, g2i0, g2o0, g2t0;

    logic        req1, we1;
    logic [8:0]  addr1;
    logic [31:0] wdata1;
    logic        ack1, err1, irq1;
    logic [31:0] rdata1;
    logic [31:0] gi1, go1, gt1, g2i1, g2o1, g2t1;

    int n_chk  = 0;
    int n_fail = 0;

    logic        s_ack, s_err, s_irq;
    logic [31:0] s_rd, s_o, s_t;

    always #5 clk = ~clk;

    gpio_ctrl #(.C_IS_DUAL(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .reg_req(req0), .reg_we(we0), .reg_addr(addr0), .reg_wdata(wdata0),
        .reg_ack(ack0), .reg_err(err0), .reg_rdata(rdata0),
        .gpio_io_i(gi0), .gpio_io_o(go0), .gpio_io_t(gt0),
        .gpio2_io_i(g2i0), .gpio2_io_o(g2o0), .gpio2_io_t(g2t0),
        .ip2intc_irpt(irq0)
    );

    gpio_ctrl #(.C_IS_DUAL(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .reg_req(req1), .reg_we(we1), .reg_addr(addr1), .reg_wdata(wdata1),
        .reg_ack(ack1), .reg_err(err1), .reg_rdata(rdata1),
        .gpio_io_i(gi1), .gpio_io_o(go1), .gpio_io_t(gt1),
        .gpio2_io_i(g2i1), .gpio2_io_o(g2o1), .gpio2_io_t(g2t1),
        .ip2intc_irpt(irq1)
    );

    task automatic acc0(input logic we, input logic [8:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
        @(posedge clk); #1;
        req0 = 1'b0; we0 = 1'b0;
        s_ack = ack0; s_err = err0; s_rd = rdata0; s_irq = irq0; s_o = go0; s_t = gt0;
        @(posedge clk); #1;
    endtask

    task automatic acc1(input logic we, input logic [8:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
        @(posedge clk); #1;
        req1 = 1'b0; we1 = 1'b0;
        s_ack = ack1; s_err = err1; s_rd = rdata1; s_irq = irq1; s_o = g2o1; s_t = g2t1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        if (go0 !== 32'h0) begin $display("FAIL rst_o: got %h want %h", go0, 32'h0); n_fail++; end n_chk++;
        if (gt0 !== 32'hFFFF_FFFF) begin $display("FAIL rst_t: got %h want ffffffff", gt0); n_fail++; end n_chk++;
        if (g2t0 !== 32'hFFFF_FFFF) begin $display("FAIL rst_t2: got %h want ffffffff", g2t0); n_fail++; end n_chk++;
        if (ack0 !== 1'b0) begin $display("FAIL rst_ack: got %b want 0", ack0); n_fail++; end n_chk++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (irq0 !== 1'b0) begin $display("FAIL rst_irq%0d: got %b want 0", i, irq0); n_fail++; end n_chk++;
        end
        acc0(1'b0, 9'h000, 32'h0);
        if (s_ack !== 1'b1 || s_err !== 1'b0 || s_rd !== 32'hA5A5_A5A5) begin
            $display("FAIL rst_data: ack %b err %b rd %h want 1 0 a5a5a5a5", s_ack, s_err, s_rd); n_fail++; end n_chk++;
        acc0(1'b0, 9'h004, 32'h0);
        if (s_rd !== 32'hFFFF_FFFF) begin $display("FAIL rst_tri: got %h want ffffffff", s_rd); n_fail++; end n_chk++;
        acc0(1'b0, 9'h008, 32'h0);
        if (s_rd !== 32'h3C3C_0F0F) begin $display("FAIL rst_data2: got %h want 3c3c0f0f", s_rd); n_fail++; end n_chk++;
        acc0(1'b0, 9'h11C, 32'h0);
        if (s_rd !== 32'h0 || s_err !== 1'b0) begin $display("FAIL rst_gier: got %h err %b want 0", s_rd, s_err); n_fail++; end n_chk++;
        acc0(1'b0, 9'h120, 32'h0);
        if (s_rd !== 32'h0) begin $display("FAIL rst_isr: got %h want 0", s_rd); n_fail++; end n_chk++;
        acc0(1'b0, 9'h128, 32'h0);
        if (s_rd !== 32'h0) begin $display("FAIL rst_ier: got %h want 0", s_rd); n_fail++; end n_chk++;
        if (irq0 !== 1'b0) begin $display("FAIL rst_irq_end: got %b want 0", irq0); n_fail++; end n_chk++;
    endtask

    task automatic test_data_write();
        acc0(1'b1, 9'h004, 32'h0);
        if (s_t !== 32'h0) begin $display("FAIL wr_tri_pins: got %h want 0", s_t); n_fail++; end n_chk++;
        acc0(1'b1, 9'h000, 32'h1234_5678);
        if (s_ack !== 1'b1 || s_o !== 32'h1234_5678) begin
            $display("FAIL wr_data_pins: ack %b o %h want 1 12345678", s_ack, s_o); n_fail++; end n_chk++;
        acc0(1'b0, 9'h000, 32'h0);
        if (s_rd !== 32'h1234_5678) begin $display("FAIL rd_data_out: got %h want 12345678", s_rd); n_fail++; end n_chk++;
        acc0(1'b0, 9'h006, 32'h0);
        if (s_rd !== 32'h0 || s_err !== 1'b0) begin $display("FAIL lane_ignore: got %h err %b want 0 0", s_rd, s_err); n_fail++; end n_chk++;
    endtask

    task automatic test_irq();
        acc0(1'b1, 9'h004, 32'hFFFF_FFFF);
        acc0(1'b1, 9'h11C, 32'h8000_0000);
        acc0(1'b1, 9'h128, 32'h1);
        @(posedge clk); #1;
        gi0[3] = ~gi0[3];
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (dut0.isr_q !== 2'b00) begin $display("FAIL isr_n1: got %b want 00", dut0.isr_q); n_fail++; end n_chk++;
        @(posedge clk); #1;
        if (dut0.isr_q !== 2'b01 || irq0 !== 1'b0) begin
            $display("FAIL isr_n2: isr %b irq %b want 01 0", dut0.isr_q, irq0); n_fail++; end n_chk++;
        @(posedge clk); #1;
        if (irq0 !== 1'b1) begin $display("FAIL irq_n3: got %b want 1", irq0); n_fail++; end n_chk++;
        acc0(1'b1, 9'h120, 32'h1);
        if (s_irq !== 1'b1) begin $display("FAIL irq_at_ack: got %b want 1", s_irq); n_fail++; end n_chk++;
        if (irq0 !== 1'b0) begin $display("FAIL irq_clear: got %b want 0", irq0); n_fail++; end n_chk++;
    endtask

    task automatic test_tri_and_ch2();
        acc0(1'b1, 9'h004, 32'hFFFF_FFF7);
        @(posedge clk); #1;
        gi0[3] = ~gi0[3];
        repeat (5) @(posedge clk);
        #1;
        acc0(1'b0, 9'h120, 32'h0);
        if (s_rd !== 32'h0) begin $display("FAIL tri0_isr: got %h want 0", s_rd); n_fail++; end n_chk++;
        acc0(1'b1, 9'h128, 32'h2);
        @(posedge clk); #1;
        g2i0[0] = ~g2i0[0];
        repeat (4) @(posedge clk);
        #1;
        if (irq0 !== 1'b1) begin $display("FAIL ch2_irq: got %b want 1", irq0); n_fail++; end n_chk++;
        acc0(1'b0, 9'h120, 32'h0);
        if (s_rd !== 32'h2) begin $display("FAIL ch2_isr: got %h want 2", s_rd); n_fail++; end n_chk++;
        acc0(1'b1, 9'h120, 32'h2);
        if (irq0 !== 1'b0) begin $display("FAIL ch2_clear: got %b want 0", irq0); n_fail++; end n_chk++;
        acc0(1'b1, 9'h004, 32'hFFFF_FFFF);
    endtask

    task automatic test_set_wins();
        acc0(1'b1, 9'h128, 32'h1);
        @(posedge clk); #1;
        gi0[5] = ~gi0[5];
        repeat (4) @(posedge clk);
        #1;
        acc0(1'b0, 9'h120, 32'h0);
        if (s_rd !== 32'h1) begin $display("FAIL sw_pre: got %h want 1", s_rd); n_fail++; end n_chk++;
        @(posedge clk); #1;
        gi0[6] = ~gi0[6];
        @(posedge clk); #1;
        acc0(1'b1, 9'h120, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        acc0(1'b0, 9'h120, 32'h0);
        if (s_rd !== 32'h1) begin $display("FAIL set_wins: got %h want 1", s_rd); n_fail++; end n_chk++;
        acc0(1'b1, 9'h120, 32'h1);
        acc0(1'b0, 9'h120, 32'h0);
        if (s_rd !== 32'h0) begin $display("FAIL tow_clear: got %h want 0", s_rd); n_fail++; end n_chk++;
    endtask

    task automatic test_unmapped();
        acc0(1'b0, 9'h104, 32'h0);
        if (s_ack !== 1'b1 || s_err !== 1'b1 || s_rd !== 32'h0) begin
            $display("FAIL unmap_rd: ack %b err %b rd %h want 1 1 0", s_ack, s_err, s_rd); n_fail++; end n_chk++;
        acc0(1'b1, 9'h104, 32'hFFFF_FFFF);
        if (s_err !== 1'b1) begin $display("FAIL unmap_wr: err %b want 1", s_err); n_fail++; end n_chk++;
        acc0(1'b0, 9'h11C, 32'h0);
        if (s_rd !== 32'h8000_0000) begin $display("FAIL unmap_nochg: got %h want 80000000", s_rd); n_fail++; end n_chk++;
    endtask

    task automatic test_single_channel();
        acc1(1'b1, 9'h008, 32'hFFFF_FFFF);
        if (s_ack !== 1'b1 || s_err !== 1'b1 || s_o !== 32'h0) begin
            $display("FAIL nd_wr2: ack %b err %b o2 %h want 1 1 0", s_ack, s_err, s_o); n_fail++; end n_chk++;
        acc1(1'b1, 9'h00C, 32'h0);
        if (s_err !== 1'b1 || s_t !== 32'hFFFF_FFFF) begin
            $display("FAIL nd_tri2: err %b t2 %h want 1 ffffffff", s_err, s_t); n_fail++; end n_chk++;
        acc1(1'b1, 9'h11C, 32'h8000_0000);
        acc1(1'b1, 9'h128, 32'h3);
        @(posedge clk); #1;
        g2i1 = ~g2i1;
        repeat (5) @(posedge clk);
        #1;
        if (irq1 !== 1'b0) begin $display("FAIL nd_irq: got %b want 0", irq1); n_fail++; end n_chk++;
        acc1(1'b0, 9'h120, 32'h0);
        if (s_rd !== 32'h0) begin $display("FAIL nd_isr: got %h want 0", s_rd); n_fail++; end n_chk++;
    endtask

    task automatic test_reset_mid_resp();
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 9'h004; wdata0 = 32'h0;
        @(posedge clk); #1;
        req0 = 1'b0; we0 = 1'b0;
        if (ack0 !== 1'b1 || gt0 !== 32'h0) begin
            $display("FAIL mid_pre: ack %b t %h want 1 0", ack0, gt0); n_fail++; end n_chk++;
        rst_n = 1'b0;
        #1;
        if (ack0 !== 1'b0 || gt0 !== 32'hFFFF_FFFF || go0 !== 32'h0 || dut0.gier_q !== 1'b0) begin
            $display("FAIL mid_reset: ack %b t %h o %h gier %b want 0 ffffffff 0 0", ack0, gt0, go0, dut0.gier_q);
            n_fail++; end n_chk++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (ack0 !== 1'b0) begin $display("FAIL post_reset_ack%0d: got %b want 0", i, ack0); n_fail++; end n_chk++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        gi0 = 32'hA5A5_A5A5; g2i0 = 32'h3C3C_0F0F;
        gi1 = 32'h0; g2i1 = 32'h0;
        #23 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_data_write();
        test_irq();
        test_tri_and_ch2();
        test_set_wins();
        test_unmapped();
        test_single_channel();
        test_reset_mid_resp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
Register-mapped controller for the two-channel GPIO datapath. It owns the data and tri-state registers that drive gpio_io_o/_t and gpio2_io_o/_t, and synchronises gpio_io_i and gpio2_io_i. It detects input changes, maintains interrupt status/enable/global-enable state and generates ip2intc_irpt. It is reached from the bus side over a simple req/ack register port, so it is bus-agnostic and sits behind the AXI-Lite slave.

Parameters:
C_GPIO_WIDTH, 32, channel 1 width (1..32)
C_GPIO2_WIDTH, 32, channel 2 width (1..32)
C_IS_DUAL, 1, 1 = channel 2 present; 0 = channel 2 absent
C_DOUT_DEFAULT, 32'h0, reset value of channel 1 data register
C_TRI_DEFAULT, 32'hFFFF_FFFF, reset value of channel 1 tri register
C_DOUT_DEFAULT_2, 32'h0, reset value of channel 2 data register
C_TRI_DEFAULT_2, 32'hFFFF_FFFF, reset value of channel 2 tri register

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  reset, asynchronous, active-low
reg_req  in  1  register access request
reg_we  in  1  1 = write, 0 = read
reg_addr  in  9  byte address; bits [1:0] ignored
reg_wdata  in  32  write data
reg_ack  out  1  one-cycle completion pulse
reg_err  out  1  unmapped address; valid with reg_ack
reg_rdata  out  32  read data; valid with reg_ack
gpio_io_i  in  C_GPIO_WIDTH  channel 1 pins in (asynchronous)
gpio_io_o  out  C_GPIO_WIDTH  channel 1 data register
gpio_io_t  out  C_GPIO_WIDTH  channel 1 tri register (1 = input)
gpio2_io_i  in  C_GPIO2_WIDTH  channel 2 pins in
gpio2_io_o  out  C_GPIO2_WIDTH  channel 2 data register
gpio2_io_t  out  C_GPIO2_WIDTH  channel 2 tri register
ip2intc_irpt  out  1  level interrupt, registered

Behaviour:
- Reset values: gpio_io_o = C_DOUT_DEFAULT; gpio_io_t = C_TRI_DEFAULT; channel 2 likewise from the _2 defaults. ISR, IER, GIER, ip2intc_irpt, reg_ack, reg_err and reg_rdata are all 0. FSM = IDLE; arm counter = 0.
- Register map:
  - 0x000 GPIO_DATA
  - 0x004 GPIO_TRI
  - 0x008 GPIO2_DATA
  - 0x00C GPIO2_TRI
  - 0x11C GIER (bit 31)
  - 0x120 ISR (bits 1:0, toggle-on-write)
  - 0x128 IER (bits 1:0)
  - All other addresses are unmapped.
- DATA read returns the synchronised pin value for bits with tri=1 and the data register for bits with tri=0. Bits at or above the channel width read as 0; writes to them are dropped.
- FSM IDLE/RESP:
  - IDLE with reg_req=1: perform the write or capture the read, then go to RESP.
  - RESP: reg_ack=1 for exactly one cycle, rdata/err valid; return to IDLE.
  - reg_req is ignored while in RESP. Maximum throughput is one access per 2 cycles. Write effects are visible on the pins in the RESP cycle.
- Unmapped access: reg_ack=1, reg_err=1, reg_rdata=0, no state change. With C_IS_DUAL=0, 0x008 and 0x00C are unmapped, gpio2_io_o=0, gpio2_io_t=all ones, and ISR[1] is never set.
- Synchroniser: two flops per input bit. The change detector compares sync stage 2 with a prev register.
  - ISR[ch] sets when any bit with tri=1 differs.
  - A pin edge sampled at clk edge N makes ISR visible after edge N+2 and ip2intc_irpt after N+3.
- Arm counter: 2-bit counter after reset. Detection is suppressed until the sync pipeline has filled (3 edges), so no spurious ISR follows reset.
- ISR write: each written 1 toggles that bit. If a hardware set and a TOW on the same bit occur in the same cycle, the set wins (bit ends at 1).
- ip2intc_irpt: registered GIER & |(ISR & IER). It deasserts one cycle after the ISR clear, IER clear or GIER clear takes effect.
- Tri change: flipping a bit from 0 to 1 does not itself raise ISR. Comparison uses tri as of the current cycle.
- rst_n assertion mid-transaction aborts it: no ack is issued and all state returns to reset values asynchronously.

Decomposition:
- Package gpio_ctrl_pkg holds:
  - register offset localparams (GPIO_DATA_OFS … IER_OFS)
  - GIER_EN_BIT = 31
  - ISR/IER bit indices CH1 = 0, CH2 = 1
  - FSM enum typedef {IDLE, RESP}
- Sub-module gpio_chan (parameter WIDTH, DOUT_DEF, TRI_DEF), instantiated once per channel; the second instance is generate-gated by C_IS_DUAL. It contains the data/tri registers, 2-flop synchroniser, prev register and change pulse output.
- The top level holds the FSM, address decode, ISR/IER/GIER, arm counter and irq register.

Test Plan:
- Reset then read all registers -> DATA=pins for tri=1 bits, TRI=32'hFFFF_FFFF, GIER/ISR/IER=0, err=0; no irq while pins=32'hA5A5_A5A5 are static.
- Write TRI=0, DATA=32'h1234_5678 -> gpio_io_t=0 and gpio_io_o=32'h1234_5678 in the ack cycle; read DATA returns 32'h1234_5678.
- GIER=32'h8000_0000, IER=1, TRI=all 1, toggle gpio_io_i[3] at edge N -> ISR=1 after N+2, irpt=1 after N+3; write ISR=1 -> irpt=0 one cycle after ack.
- Pin change on a tri=0 bit -> ISR stays 0; change on gpio2 with IER=2'b10 -> ISR[1]=1 and irpt=1.
- ISR TOW write coincident with a new channel 1 edge -> ISR[0] remains 1.
- Read 0x104 -> ack=1, err=1, rdata=0; C_IS_DUAL=0 build, write 0x008 -> err=1 and gpio2_io_o stays 0; rst_n low mid-RESP -> no ack, outputs return to defaults.
